// File: rtl/synth_ctrl_pkg.sv
`default_nettype none
// synth_ctrl_pkg: shared MIDI status encodings, message-length helper and the CC event record.

package synth_ctrl_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CTRL     = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHAN_AT  = 4'hD;
    localparam logic [3:0] ST_PITCH    = 4'hE;

    localparam logic [13:0] PITCH_CENTRE = 14'h2000;

    // Channel field is sized for the full 16-slot case; narrower builds use the low bits.
    localparam int CC_CH_W = 4;

    typedef struct packed {
        logic [CC_CH_W-1:0] ch;
        logic [6:0]         num;
        logic [13:0]        data;
    } cc_event_t;

    // Number of data bytes following a channel-voice status nibble (0 for non channel-voice).
    function automatic logic [1:0] midi_msg_len(input logic [3:0] nibble);
        case (nibble)
            ST_PROG, ST_CHAN_AT:                                   midi_msg_len = 2'd1;
            ST_NOTE_OFF, ST_NOTE_ON, ST_POLY_AT, ST_CTRL, ST_PITCH: midi_msg_len = 2'd2;
            default:                                               midi_msg_len = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_event_fifo.sv
`default_nettype none
// ctrl_event_fifo: first-word-fall-through FIFO of cc_event_t with drop indication on overflow.

module ctrl_event_fifo
    import synth_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  cc_event_t push_data_i,
    input  logic      pop_i,
    output logic      valid_o,
    output cc_event_t head_o,
    output logic      drop_o
);

    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    cc_event_t          mem_q [FIFO_DEPTH];

    logic full;
    logic push_ok;
    logic pop_ok;

    assign valid_o = (count_q != '0);
    assign full    = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    assign pop_ok  = pop_i && valid_o;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign push_ok = push_i && (!full || pop_ok);
    assign drop_o  = push_i && !push_ok;
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/midi_ctrl_decoder.sv
`default_nettype none
// midi_ctrl_decoder: running-status MIDI channel-voice parser with per-slot pitch/program state
// and a CC event FIFO. Define CTRL_14BIT_EN to pair CC 0-31 (MSB) with CC 32-63 (LSB).

module midi_ctrl_decoder
    import synth_ctrl_pkg::*;
#(
    parameter int CHANNELS   = 16,
    parameter int CH_WIDTH   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_reg_N,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    input  logic [3:0]              midi_ch_base,
    output logic [CHANNELS*14-1:0]  pitch_val,
    output logic [CHANNELS-1:0]     pitch_upd,
    output logic [CHANNELS*7-1:0]   prg_val,
    output logic [CHANNELS-1:0]     prg_upd,
    output logic                    cc_valid,
    input  logic                    cc_ready,
    output logic [CH_WIDTH-1:0]     cc_ch,
    output logic [6:0]              cc_num,
    output logic [13:0]             cc_data,
    output logic                    cc_overflow,
    input  logic                    cc_ovf_clr
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_D1 = 2'd1,
        S_WAIT_D2 = 2'd2
    } parse_state_t;

    parse_state_t        state_q, state_d;
    logic [3:0]          status_q, status_d;
    logic [CH_WIDTH-1:0] slot_q, slot_d;
    logic                slot_ok_q, slot_ok_d;
    logic [6:0]          d1_q, d1_d;

    logic                msg_done;
    logic                msg_act;
    logic                cc_push;
    logic [6:0]          fin_d1;
    logic [6:0]          fin_d2;
    logic [4:0]          ch_diff;
    logic                ch_in_range;

    logic [13:0]         pitch_q [CHANNELS];
    logic [6:0]          prg_q   [CHANNELS];
    logic [CHANNELS-1:0] pitch_upd_q;
    logic [CHANNELS-1:0] prg_upd_q;
    logic                cc_ovf_q;

    cc_event_t           cc_ev;
    cc_event_t           cc_head;
    logic                fifo_drop;

    // Borrow out of the 5-bit subtract flags a channel below the base.
    assign ch_diff     = {1'b0, byte_data[3:0]} - {1'b0, midi_ch_base};
    assign ch_in_range = !ch_diff[4] && ({28'd0, ch_diff[3:0]} < CHANNELS);

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q   <= S_IDLE;
            status_q  <= '0;
            slot_q    <= '0;
            slot_ok_q <= 1'b0;
            d1_q      <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            slot_q    <= slot_d;
            slot_ok_q <= slot_ok_d;
            d1_q      <= d1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        slot_d    = slot_q;
        slot_ok_d = slot_ok_q;
        d1_d      = d1_q;
        msg_done  = 1'b0;
        fin_d1    = d1_q;
        fin_d2    = byte_data[6:0];
        if (byte_valid) begin
            if (byte_data[7]) begin
                if (byte_data[7:4] != 4'hF) begin
                    status_d  = byte_data[7:4];
                    slot_d    = ch_diff[CH_WIDTH-1:0];
                    slot_ok_d = ch_in_range;
                    state_d   = S_WAIT_D1;
                end else if (!byte_data[3]) begin
                    // System common/exclusive cancels running status; realtime falls through untouched.
                    status_d = '0;
                    state_d  = S_IDLE;
                end
            end else begin
                case (state_q)
                    S_WAIT_D1: begin
                        if (midi_msg_len(status_q) == 2'd1) begin
                            msg_done = 1'b1;
                            fin_d1   = byte_data[6:0];
                        end else begin
                            d1_d    = byte_data[6:0];
                            state_d = S_WAIT_D2;
                        end
                    end
                    S_WAIT_D2: begin
                        msg_done = 1'b1;
                        state_d  = S_WAIT_D1;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign msg_act = msg_done && slot_ok_q;
    assign cc_push = msg_act && (status_q == ST_CTRL);

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int k = 0; k < CHANNELS; k++) begin
                pitch_q[k] <= PITCH_CENTRE;
                prg_q[k]   <= '0;
            end
            pitch_upd_q <= '0;
            prg_upd_q   <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                pitch_upd_q[k] <= 1'b0;
                prg_upd_q[k]   <= 1'b0;
                if (msg_act && (slot_q == CH_WIDTH'(k))) begin
                    if (status_q == ST_PITCH) begin
                        pitch_q[k]     <= {fin_d2, fin_d1};
                        pitch_upd_q[k] <= 1'b1;
                    end
                    if (status_q == ST_PROG) begin
                        prg_q[k]     <= fin_d1;
                        prg_upd_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef CTRL_14BIT_EN
    logic [6:0] msb_q [CHANNELS][32];

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int k = 0; k < CHANNELS; k++) begin
                for (int j = 0; j < 32; j++) begin
                    msb_q[k][j] <= '0;
                end
            end
        end else if (cc_push && (fin_d1[6:5] == 2'b00)) begin
            msb_q[slot_q][fin_d1[4:0]] <= fin_d2;
        end
    end
`endif

    always_comb begin
        cc_ev.ch   = CC_CH_W'(slot_q);
        cc_ev.num  = fin_d1;
        cc_ev.data = {7'h0, fin_d2};
`ifdef CTRL_14BIT_EN
        if (fin_d1[6:5] == 2'b00) begin
            cc_ev.data = {fin_d2, 7'h0};
        end else if (fin_d1[6:5] == 2'b01) begin
            cc_ev.num  = {2'b00, fin_d1[4:0]};
            cc_ev.data = {msb_q[slot_q][fin_d1[4:0]], fin_d2};
        end
`endif
    end

    ctrl_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_cc_fifo (
        .clk         (CLOCK_50),
        .rst_n       (reset_reg_N),
        .push_i      (cc_push),
        .push_data_i (cc_ev),
        .pop_i       (cc_ready),
        .valid_o     (cc_valid),
        .head_o      (cc_head),
        .drop_o      (fifo_drop)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            cc_ovf_q <= 1'b0;
        end else begin
            cc_ovf_q <= fifo_drop | (cc_ovf_q & ~cc_ovf_clr);
        end
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_pack
            assign pitch_val[14*k +: 14] = pitch_q[k];
            assign prg_val[7*k +: 7]     = prg_q[k];
        end
    endgenerate

    assign pitch_upd   = pitch_upd_q;
    assign prg_upd     = prg_upd_q;
    assign cc_ch       = cc_head.ch[CH_WIDTH-1:0];
    assign cc_num      = cc_head.num;
    assign cc_data     = cc_head.data;
    assign cc_overflow = cc_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_midi_ctrl_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_midi_ctrl_decoder: scoreboard bench with a queue-based MIDI reference model.

module tb_midi_ctrl_decoder;

    localparam int CHN   = 16;
    localparam int DEPTH = 8;

    logic               CLOCK_50 = 1'b0;
    logic               reset_reg_N;
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic [3:0]         midi_ch_base;
    logic [CHN*14-1:0]  pitch_val;
    logic [CHN-1:0]     pitch_upd;
    logic [CHN*7-1:0]   prg_val;
    logic [CHN-1:0]     prg_upd;
    logic               cc_valid;
    logic               cc_ready;
    logic [3:0]         cc_ch;
    logic [6:0]         cc_num;
    logic [13:0]        cc_data;
    logic               cc_overflow;
    logic               cc_ovf_clr;

    always #5 CLOCK_50 = ~CLOCK_50;

    midi_ctrl_decoder #(
        .CHANNELS(CHN), .CH_WIDTH(4), .FIFO_DEPTH(DEPTH), .FIFO_AW(3)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_reg_N(reset_reg_N), .byte_valid(byte_valid),
        .byte_data(byte_data), .midi_ch_base(midi_ch_base), .pitch_val(pitch_val),
        .pitch_upd(pitch_upd), .prg_val(prg_val), .prg_upd(prg_upd), .cc_valid(cc_valid),
        .cc_ready(cc_ready), .cc_ch(cc_ch), .cc_num(cc_num), .cc_data(cc_data),
        .cc_overflow(cc_overflow), .cc_ovf_clr(cc_ovf_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model state
    typedef struct { int slot; int val; } upd_t;
    typedef struct { int ch; int num; int data; } cc_t;

    int   m_rs;
    int   m_slot;
    int   m_data[$];
    int   pv[CHN];
    int   pg[CHN];
    int   m_occ;
    bit   m_ovf;
    upd_t exp_pitch[$];
    upd_t exp_prg[$];
    cc_t  exp_cc[$];
`ifdef CTRL_14BIT_EN
    int   msb[CHN][32];
`endif

    task automatic model_reset();
        m_rs = -1;
        m_slot = 0;
        m_data.delete();
        m_occ = 0;
        m_ovf = 1'b0;
        exp_pitch.delete();
        exp_prg.delete();
        exp_cc.delete();
        for (int k = 0; k < CHN; k++) begin
            pv[k] = 'h2000;
            pg[k] = 0;
`ifdef CTRL_14BIT_EN
            for (int j = 0; j < 32; j++) msb[k][j] = 0;
`endif
        end
    endtask

    task automatic model_step();
        bit   pop_now;
        bit   push_now;
        bit   drop;
        int   b;
        int   d1;
        int   d2;
        cc_t  ev;
        upd_t u;
        pop_now  = cc_ready && (m_occ > 0);
        push_now = 1'b0;
        ev = '{0, 0, 0};
        if (byte_valid) begin
            b = int'(byte_data);
            if (b >= 'hF8) begin
                // realtime: no effect
            end else if (b >= 'hF0) begin
                m_rs = -1;
                m_data.delete();
            end else if (b >= 'h80) begin
                m_rs = b / 16;
                m_slot = (b % 16) - int'(midi_ch_base);
                m_data.delete();
            end else if (m_rs >= 0) begin
                m_data.push_back(b);
                if (m_data.size() == (((m_rs == 12) || (m_rs == 13)) ? 1 : 2)) begin
                    if (m_slot >= 0 && m_slot < CHN) begin
                        d1 = m_data[0];
                        d2 = (m_data.size() > 1) ? m_data[1] : 0;
                        if (m_rs == 14) begin
                            pv[m_slot] = d2 * 128 + d1;
                            u = '{m_slot, pv[m_slot]};
                            exp_pitch.push_back(u);
                        end else if (m_rs == 12) begin
                            pg[m_slot] = d1;
                            u = '{m_slot, d1};
                            exp_prg.push_back(u);
                        end else if (m_rs == 11) begin
                            push_now = 1'b1;
                            ev = '{m_slot, d1, d2};
`ifdef CTRL_14BIT_EN
                            if (d1 < 32) begin
                                msb[m_slot][d1] = d2;
                                ev.data = d2 * 128;
                            end else if (d1 < 64) begin
                                ev.num  = d1 - 32;
                                ev.data = msb[m_slot][d1 - 32] * 128 + d2;
                            end
`endif
                        end
                    end
                    m_data.delete();
                end
            end
        end
        drop = push_now && (m_occ == DEPTH) && !pop_now;
        if (push_now && !drop) begin
            exp_cc.push_back(ev);
            m_occ++;
        end
        if (pop_now) m_occ--;
        if (drop) m_ovf = 1'b1;
        else if (cc_ovf_clr) m_ovf = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge CLOCK_50 or negedge reset_reg_N);
            if (!reset_reg_N) model_reset();
            else model_step();
        end
    end

    // Monitor: compares DUT output events against the scoreboard queues
    initial begin
        upd_t u;
        cc_t  c;
        forever begin
            @(negedge CLOCK_50);
            if (reset_reg_N === 1'b1) begin
                for (int k = 0; k < CHN; k++) begin
                    if (pitch_upd[k]) begin
                        check("pitch_upd_expected", exp_pitch.size() > 0, 1);
                        if (exp_pitch.size() > 0) begin
                            u = exp_pitch.pop_front();
                            check("pitch_upd_slot", k, u.slot);
                            check("pitch_val_on_upd", pitch_val[k*14 +: 14], u.val);
                        end
                    end
                    if (prg_upd[k]) begin
                        check("prg_upd_expected", exp_prg.size() > 0, 1);
                        if (exp_prg.size() > 0) begin
                            u = exp_prg.pop_front();
                            check("prg_upd_slot", k, u.slot);
                            check("prg_val_on_upd", prg_val[k*7 +: 7], u.val);
                        end
                    end
                end
                check("cc_valid", cc_valid, m_occ > 0);
                check("cc_overflow", cc_overflow, m_ovf);
                if (cc_valid && cc_ready) begin
                    check("cc_pop_expected", exp_cc.size() > 0, 1);
                    if (exp_cc.size() > 0) begin
                        c = exp_cc.pop_front();
                        check("cc_ch", cc_ch, c.ch);
                        check("cc_num", cc_num, c.num);
                        check("cc_data", cc_data, c.data);
                    end
                end
            end
        end
    end

    task automatic tick(input bit v, input logic [7:0] b);
        byte_valid = v;
        byte_data  = b;
        @(posedge CLOCK_50);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < CHN; k++) begin
            check({tag, "_pitch_val"}, pitch_val[k*14 +: 14], 14'h2000);
            check({tag, "_prg_val"}, prg_val[k*7 +: 7], 7'h0);
        end
        check({tag, "_pitch_upd"}, pitch_upd, 0);
        check({tag, "_prg_upd"}, prg_upd, 0);
        check({tag, "_cc_valid"}, cc_valid, 0);
        check({tag, "_cc_head"}, {cc_ch, cc_num, cc_data}, 0);
        check({tag, "_cc_overflow"}, cc_overflow, 0);
    endtask

    task automatic check_arrays();
        for (int k = 0; k < CHN; k++) begin
            check($sformatf("pitch_val[%0d]", k), pitch_val[k*14 +: 14], pv[k]);
            check($sformatf("prg_val[%0d]", k), prg_val[k*7 +: 7], pg[k]);
        end
    endtask

    initial begin
        int r;
        int ready_bias;
        reset_reg_N  = 1'b0;
        byte_valid   = 1'b0;
        byte_data    = 8'h00;
        midi_ch_base = 4'd0;
        cc_ready     = 1'b0;
        cc_ovf_clr   = 1'b0;
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_reset_state("reset");
        reset_reg_N = 1'b1;
        idle(1);

        // 1: pitch bend centre on slot 3
        send(8'hE3); send(8'h00); send(8'h40);
        check("t1_pitch_upd", pitch_upd, 16'h0008);
        check("t1_pitch_val3", pitch_val[3*14 +: 14], 14'h2000);
        idle(1);
        check("t1_pitch_upd_clear", pitch_upd, 16'h0000);

        // 2: program change with running status
        send(8'hC5); send(8'h0A);
        check("t2_prg_upd_a", prg_upd, 16'h0020);
        check("t2_prg_val_a", prg_val[5*7 +: 7], 7'h0A);
        send(8'h0B);
        check("t2_prg_upd_b", prg_upd, 16'h0020);
        check("t2_prg_val_b", prg_val[5*7 +: 7], 7'h0B);
        idle(1);

        // 3: channel base offset
        midi_ch_base = 4'd2;
        send(8'hB1); send(8'h07); send(8'h64);
        idle(1);
        check("t3_out_of_range", cc_valid, 0);
        send(8'hB2); send(8'h07); send(8'h64);
        check("t3_cc_valid", cc_valid, 1);
        check("t3_cc_ch", cc_ch, 4'd0);
        check("t3_cc_num", cc_num, 7'd7);
`ifdef CTRL_14BIT_EN
        check("t3_cc_data", cc_data, 14'h3200);
`else
        check("t3_cc_data", cc_data, 14'h0064);
`endif
        cc_ready = 1'b1;
        idle(1);
        cc_ready = 1'b0;
        check("t3_popped", cc_valid, 0);
        midi_ch_base = 4'd0;

        // 4: realtime inside a message, system byte aborting a message
        send(8'hE0); send(8'h10); send(8'hF8); send(8'h20);
        check("t4_pitch_upd", pitch_upd, 16'h0001);
        check("t4_pitch_val0", pitch_val[13:0], 14'h1010);
        send(8'hE0); send(8'h10); send(8'hF0); send(8'h20);
        check("t4_abort_upd", pitch_upd, 16'h0000);
        idle(1);
        check("t4_abort_val", pitch_val[13:0], 14'h1010);

        // 5: fill FIFO past capacity, then drain in order
        send(8'hB0);
        for (int i = 0; i < 9; i++) begin
            send(8'(i));
            send(8'(i + 16));
        end
        idle(1);
        check("t5_overflow", cc_overflow, 1);
        check("t5_valid_full", cc_valid, 1);
        cc_ready = 1'b1;
        idle(DEPTH);
        cc_ready = 1'b0;
        check("t5_drained", cc_valid, 0);
        cc_ovf_clr = 1'b1;
        idle(1);
        cc_ovf_clr = 1'b0;
        check("t5_ovf_cleared", cc_overflow, 0);

`ifdef CTRL_14BIT_EN
        // 6: 14-bit CC pairing
        send(8'hB0); send(8'h01); send(8'h40);
        send(8'hB0); send(8'h21); send(8'h11);
        idle(1);
        check("t6_msb_num", cc_num, 7'd1);
        check("t6_msb_data", cc_data, 14'h2000);
        cc_ready = 1'b1;
        idle(1);
        cc_ready = 1'b0;
        check("t6_lsb_num", cc_num, 7'd1);
        check("t6_lsb_data", cc_data, 14'h2011);
        cc_ready = 1'b1;
        idle(1);
        cc_ready = 1'b0;
`endif

        // Randomised traffic
        ready_bias = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) ready_bias = (ready_bias == 3) ? 1 : 3;
            if (i % 40 == 0) midi_ch_base = 4'($urandom_range(0, 3));
            cc_ready   = ($urandom_range(0, 3) < ready_bias);
            cc_ovf_clr = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 99);
            if (r < 10) send({4'hB, 4'($urandom_range(0, 15))});
            else if (r < 22) send(8'($urandom_range(8'h80, 8'hEF)));
            else if (r < 25) send(8'($urandom_range(8'hF8, 8'hFF)));
            else if (r < 27) send(8'($urandom_range(8'hF0, 8'hF7)));
            else if (r < 32) idle(1);
            else send(8'($urandom_range(0, 127)));
            if (i % 200 == 199) check_arrays();
        end
        cc_ovf_clr = 1'b0;
        check_arrays();

        // Reset in the middle of a message
        cc_ready = 1'b0;
        send(8'hB0); send(8'h05); send(8'h06);
        send(8'hE0); send(8'h10);
        reset_reg_N = 1'b0;
        #2;
        check_reset_state("midreset");
        @(posedge CLOCK_50);
        #1;
        reset_reg_N = 1'b1;
        send(8'h20);
        idle(1);
        check("midreset_no_upd", pitch_upd, 16'h0000);
        check("midreset_pitch0", pitch_val[13:0], 14'h2000);

        // Final drain
        cc_ready = 1'b1;
        idle(12);
        check("end_cc_queue_empty", exp_cc.size(), 0);
        check("end_pitch_queue_empty", exp_pitch.size(), 0);
        check("end_prg_queue_empty", exp_prg.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
